aux_cnt_gen: RTL
================

AUX_CNT_GEN -- requirements
Module: aux_cnt_gen

Interface
REQ-001 The block SHALL have exactly one clock and one reset: the reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start_i  input  1  request to begin one count sequence; sampled only in IDLE.
REQ-005 en_i  input  1  advance strobe from the consumer FSM; high = step the counter this cycle.
REQ-006 sz_full_i  input  6  terminal index of the sequence; captured at an accepted start.
REQ-007 aux_reg_o  output  6  current auxiliary count value, drives the consumer-side terminal comparator.
REQ-008 busy_o  output  1  high while in RUN or DONE.
REQ-009 last_o  output  1  high in RUN when aux_reg_o equals the captured terminal index.
REQ-010 done_o  output  1  one-cycle pulse marking sequence completion.
REQ-011 err_o  output  1  sticky protocol-error flag (see Configuration).

Function
REQ-012 The block SHALL implement the states IDLE, RUN and DONE, encoded in a 2-bit register.
REQ-013 In IDLE with start_i=1, it SHALL capture sz_full_i into sz_q, load aux_reg_o with 0 and enter RUN on the next edge.
REQ-014 In RUN with en_i=1 and aux_reg_o != sz_q, it SHALL increment aux_reg_o by 1.
REQ-015 In RUN with en_i=1 and aux_reg_o == sz_q, it SHALL hold aux_reg_o and enter DONE.
REQ-016 In RUN with en_i=0, it SHALL hold aux_reg_o and the state, with no cycle limit.
REQ-017 In DONE, it SHALL assert done_o for exactly that one cycle and return to IDLE on the next edge.
REQ-018 A sequence SHALL consume exactly sz_q+1 en_i strobes, with aux_reg_o taking values 0..sz_q inclusive.
REQ-019 aux_reg_o SHALL retain its final value in DONE and IDLE until the next accepted start.
REQ-020 Arithmetic SHALL be 6-bit unsigned: sz_q=63 ends at 63 with no wrap, and aux_reg_o never exceeds sz_q.
REQ-021 sz_q=0 SHALL be legal: the first en_i strobe in RUN enters DONE with aux_reg_o=0.
REQ-022 start_i in RUN or DONE SHALL be ignored: no recapture and no counter change.
REQ-023 A change of sz_full_i after capture SHALL NOT affect the running sequence.
REQ-024 last_o SHALL be combinational from state, aux_reg_o and sz_q, and is 0 outside RUN.

Reset
REQ-025 rst=1 SHALL force, on the next edge: state=IDLE, aux_reg_o=0, sz_q=0, done_o=0, err_o=0.
REQ-026 While state=IDLE after reset, busy_o=0 and last_o=0.
REQ-027 rst SHALL take priority over start_i and en_i in the same cycle.
REQ-028 Reset mid-sequence (RUN or DONE) SHALL abort the sequence with no done_o pulse.

Configuration
REQ-029 Macro AUX_CNT_ERR_EN SHALL control protocol-error detection.
REQ-030 When AUX_CNT_ERR_EN is defined, err_o SHALL set when start_i=1 in RUN or DONE, or when a start is accepted with sz_full_i=0.
REQ-031 When AUX_CNT_ERR_EN is defined, err_o SHALL stay set until rst, or until a later start is accepted with sz_full_i != 0.
REQ-032 When AUX_CNT_ERR_EN is undefined, err_o SHALL be tied to 0, the port list SHALL be unchanged, and all other behaviour SHALL be identical.

Verification
REQ-033 Normal sequence: sz_full_i=7, start pulse, then en_i held high -> aux_reg_o steps 0..7, last_o=1 at 7, done_o pulses one cycle later, busy_o then falls; 8 strobes total.
REQ-034 Stall: sz_full_i=3, en_i pattern 1,0,0,1,1,1 -> aux_reg_o sequence 0,1,1,1,2,3, with DONE after the sixth cycle.
REQ-035 Boundaries: sz_full_i=0 -> one strobe gives done_o, and err_o=1 only with AUX_CNT_ERR_EN; sz_full_i=63 -> 64 strobes with final value 63 and no wrap.
REQ-036 Ignored start and size change: start_i re-pulsed and sz_full_i changed to 2 mid-sequence with sz_q=5 -> count still ends at 5, and err_o=1 only with AUX_CNT_ERR_EN.
REQ-037 Reset mid-operation: rst at aux_reg_o=4 -> next cycle aux_reg_o=0, IDLE, busy_o=0, no done_o, err_o=0.
REQ-038 Priority: rst=1 together with start_i=1 -> remains in IDLE; a subsequent start with sz_full_i=2 runs normally.

Source files
------------

// File: rtl/aux_cnt_gen.sv
// Auxiliary sequence counter: steps 0..sz_q on en_i strobes, then pulses done_o.
// Protocol-error detection on err_o is built only when AUX_CNT_ERR_EN is defined.
//
// state | meaning
// IDLE  | waiting for start_i; aux_reg_o holds the last final count
// RUN   | counting on en_i strobes toward the captured terminal index
// DONE  | single-cycle completion pulse, then back to IDLE
module aux_cnt_gen (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   input  logic       en_i,
   input  logic [5:0] sz_full_i,
   output logic [5:0] aux_reg_o,
   output logic       busy_o,
   output logic       last_o,
   output logic       done_o,
   output logic       err_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] aux_q, aux_d;
   logic [5:0] sz_q, sz_d;
   logic       at_term;

   assign at_term = (aux_q == sz_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         aux_q   <= 6'd0;
         sz_q    <= 6'd0;
      end else begin
         state_q <= state_d;
         aux_q   <= aux_d;
         sz_q    <= sz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      aux_d   = aux_q;
      sz_d    = sz_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               sz_d    = sz_full_i;
               aux_d   = 6'd0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // Terminal compare happens before increment, so aux never passes sz_q.
            if (en_i) begin
               if (at_term) begin
                  state_d = ST_DONE;
               end else begin
                  aux_d = aux_q + 6'd1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      busy_o    = 1'b0;
      last_o    = 1'b0;
      done_o    = 1'b0;
      aux_reg_o = aux_q;
      case (state_q)
         ST_RUN: begin
            busy_o = 1'b1;
            last_o = at_term;
         end
         ST_DONE: begin
            busy_o = 1'b1;
            done_o = 1'b1;
         end
         default: begin
            busy_o = 1'b0;
         end
      endcase
   end

`ifdef AUX_CNT_ERR_EN
   logic err_q, err_d;

   // An accepted start both sets (zero size) and clears (non-zero size) the flag.
   always_comb begin
      err_d = err_q;
      if (start_i) begin
         if (state_q == ST_IDLE) begin
            err_d = (sz_full_i == 6'd0);
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule
